// File: rtl/ps2_device_core.sv
// PS2 device-side link core (keyboard/mouse end).
// Generates the PS2 clock, transmits device-to-host frames and receives
// host-to-device command frames, answering each good frame with an ack pulse.
// Both lines are open-drain: a *_w output of 1 pulls the line low, and the
// matching *_o drive value is always 0.
module ps2_device_core #(
  parameter int CLK     = 50,  // system clock in MHz
  parameter int HALF_US = 40,  // PS2 clock half-period in us
  parameter int IDLE_US = 50   // bus-idle time needed before a transmit, in us
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  output logic       ps2_clk_w,
  output logic       ps2_clk_o,
  input  logic       ps2_data_i,
  output logic       ps2_data_w,
  output logic       ps2_data_o,
  input  logic       send_req,
  input  logic [7:0] send_data,
  output logic       send_ack,
  output logic       send_done,
  output logic       send_abort,
  output logic [7:0] rcv_data,
  output logic       rcv_vld,
  output logic       rcv_parity_err,
  output logic       rcv_frame_err,
  output logic       idle
);

  localparam int T_CYC = CLK * HALF_US;
  localparam int I_CYC = CLK * IDLE_US;
  localparam int TW    = (T_CYC > 1) ? $clog2(T_CYC) : 1;
  localparam int IW    = (I_CYC > 0) ? $clog2(I_CYC + 1) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(T_CYC - 1);
  localparam logic [IW-1:0] I_SAT  = IW'(I_CYC);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX_HIGH  = 3'd1,
    ST_TX_LOW   = 3'd2,
    ST_RX_LOW   = 3'd3,
    ST_RX_HIGH  = 3'd4,
    ST_ACK_LOW  = 3'd5,
    ST_ACK_HIGH = 3'd6
  } state_e;

  // Odd-parity bit for a data byte: makes the nine-bit total odd.
  function automatic logic odd_parity_bit(input logic [7:0] d);
    return ~(^d);
  endfunction

  // 1 when a received {parity, data} word carries an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] w);
    return ^w;
  endfunction

  // Synchronizers
  logic       clk_meta_q, sclk_q;
  logic       dat_meta_q, sdat_q;

  // FSM and datapath
  state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0] bit_q, bit_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [10:0] tx_shift_q, tx_shift_d;
  logic [8:0] rx_shift_q, rx_shift_d;
  logic [1:0] drv_hist_q;

  // Registered outputs
  logic       clk_w_q, clk_w_d;
  logic       data_w_q, data_w_d;
  logic       send_ack_q, send_ack_d;
  logic       send_done_q, send_done_d;
  logic       send_abort_q, send_abort_d;
  logic [7:0] rcv_data_q, rcv_data_d;
  logic       rcv_vld_q, rcv_vld_d;
  logic       rcv_perr_q, rcv_perr_d;
  logic       rcv_ferr_q, rcv_ferr_d;
  logic       idle_q, idle_d;

  logic       phase_end_s;
  logic       bus_idle_s;
  logic       rts_s;

  // Two-flop synchronizers for the sensed bus lines, plus a short history of
  // our own data drive so a line we just released is not mistaken for RTS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_q <= 1'b1;
      sclk_q     <= 1'b1;
      dat_meta_q <= 1'b1;
      sdat_q     <= 1'b1;
      drv_hist_q <= 2'b00;
    end else begin
      clk_meta_q <= ps2_clk_i;
      sclk_q     <= clk_meta_q;
      dat_meta_q <= ps2_data_i;
      sdat_q     <= dat_meta_q;
      drv_hist_q <= {drv_hist_q[0], data_w_q};
    end
  end

  assign phase_end_s = (timer_q == T_LAST);
  assign bus_idle_s  = sclk_q & sdat_q;
  // Host request-to-send: clock released, data pulled low by the host.
  assign rts_s       = sclk_q & ~sdat_q & ~data_w_q & ~(|drv_hist_q);

  // Next-state, datapath and next-output logic for the link FSM.
  always_comb begin
    state_d      = state_q;
    timer_d      = phase_end_s ? '0 : (timer_q + TW'(1));
    bit_d        = bit_q;
    idle_cnt_d   = '0;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    rcv_data_d   = rcv_data_q;
    rcv_perr_d   = rcv_perr_q;
    send_ack_d   = 1'b0;
    send_done_d  = 1'b0;
    send_abort_d = 1'b0;
    rcv_vld_d    = 1'b0;
    rcv_ferr_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        bit_d   = 4'd0;
        if (bus_idle_s) begin
          if (idle_cnt_q != I_SAT) begin
            idle_cnt_d = idle_cnt_q + IW'(1);
          end else begin
            idle_cnt_d = idle_cnt_q;
          end
        end else begin
          idle_cnt_d = '0;
        end
        if (rts_s) begin
          state_d = ST_RX_LOW;
        end else if (send_req && bus_idle_s && (idle_cnt_q == I_SAT)) begin
          tx_shift_d = {1'b1, odd_parity_bit(send_data), send_data, 1'b0};
          send_ack_d = 1'b1;
          idle_cnt_d = '0;
          state_d    = ST_TX_HIGH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_TX_HIGH: begin
        if (phase_end_s) begin
          if (!sclk_q && (bit_q != 4'd10)) begin
            send_abort_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_TX_LOW;
          end
        end else begin
          state_d = ST_TX_HIGH;
        end
      end

      ST_TX_LOW: begin
        if (phase_end_s) begin
          if (bit_q == 4'd10) begin
            send_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            bit_d      = bit_q + 4'd1;
            tx_shift_d = {1'b0, tx_shift_q[10:1]};
            state_d    = ST_TX_HIGH;
          end
        end else begin
          state_d = ST_TX_LOW;
        end
      end

      ST_RX_LOW: begin
        if (phase_end_s) begin
          state_d = ST_RX_HIGH;
        end else begin
          state_d = ST_RX_LOW;
        end
      end

      ST_RX_HIGH: begin
        if (phase_end_s) begin
          if (!sclk_q) begin
            state_d = ST_IDLE;
          end else if (bit_q == 4'd9) begin
            if (sdat_q) begin
              state_d = ST_ACK_LOW;
            end else begin
              rcv_ferr_d = 1'b1;
              state_d    = ST_IDLE;
            end
          end else begin
            rx_shift_d = {sdat_q, rx_shift_q[8:1]};
            bit_d      = bit_q + 4'd1;
            state_d    = ST_RX_LOW;
          end
        end else begin
          state_d = ST_RX_HIGH;
        end
      end

      ST_ACK_LOW: begin
        if (phase_end_s) begin
          state_d = ST_ACK_HIGH;
        end else begin
          state_d = ST_ACK_LOW;
        end
      end

      ST_ACK_HIGH: begin
        if (phase_end_s) begin
          rcv_data_d = rx_shift_q[7:0];
          rcv_perr_d = ~odd_parity_ok(rx_shift_q);
          rcv_vld_d  = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_ACK_HIGH;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        bit_d   = 4'd0;
      end
    endcase

    clk_w_d = (state_d == ST_TX_LOW) || (state_d == ST_RX_LOW) || (state_d == ST_ACK_LOW);
    if ((state_d == ST_TX_HIGH) || (state_d == ST_TX_LOW)) begin
      data_w_d = ~tx_shift_d[0];
    end else if ((state_d == ST_ACK_LOW) || (state_d == ST_ACK_HIGH)) begin
      data_w_d = 1'b1;
    end else begin
      data_w_d = 1'b0;
    end
    idle_d = (state_d == ST_IDLE);
  end

  // State register, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      bit_q        <= 4'd0;
      idle_cnt_q   <= '0;
      tx_shift_q   <= 11'd0;
      rx_shift_q   <= 9'd0;
      clk_w_q      <= 1'b0;
      data_w_q     <= 1'b0;
      send_ack_q   <= 1'b0;
      send_done_q  <= 1'b0;
      send_abort_q <= 1'b0;
      rcv_data_q   <= 8'd0;
      rcv_vld_q    <= 1'b0;
      rcv_perr_q   <= 1'b0;
      rcv_ferr_q   <= 1'b0;
      idle_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_q        <= bit_d;
      idle_cnt_q   <= idle_cnt_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      clk_w_q      <= clk_w_d;
      data_w_q     <= data_w_d;
      send_ack_q   <= send_ack_d;
      send_done_q  <= send_done_d;
      send_abort_q <= send_abort_d;
      rcv_data_q   <= rcv_data_d;
      rcv_vld_q    <= rcv_vld_d;
      rcv_perr_q   <= rcv_perr_d;
      rcv_ferr_q   <= rcv_ferr_d;
      idle_q       <= idle_d;
    end
  end

  assign ps2_clk_w      = clk_w_q;
  assign ps2_clk_o      = 1'b0;
  assign ps2_data_w     = data_w_q;
  assign ps2_data_o     = 1'b0;
  assign send_ack       = send_ack_q;
  assign send_done      = send_done_q;
  assign send_abort     = send_abort_q;
  assign rcv_data       = rcv_data_q;
  assign rcv_vld        = rcv_vld_q;
  assign rcv_parity_err = rcv_perr_q;
  assign rcv_frame_err  = rcv_ferr_q;
  assign idle           = idle_q;

endmodule

// File: tb/tb_ps2_device_core.sv
// Bench for ps2_device_core: a host model on open-drain lines, randomized
// bytes, and a frame-level reference model (start/data/odd parity/stop).
module tb_ps2_device_core;

  localparam int CLK_MHZ = 1;
  localparam int HALF    = 4;
  localparam int IDLE_T  = 5;
  localparam int T       = CLK_MHZ * HALF;
  localparam int I       = CLK_MHZ * IDLE_T;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       host_clk_w = 1'b0;
  logic       host_data_w = 1'b0;
  logic       dut_clk_w, dut_data_w, dut_clk_o, dut_data_o;
  logic       send_req = 1'b0;
  logic [7:0] send_data = 8'd0;
  logic       send_ack, send_done, send_abort;
  logic [7:0] rcv_data;
  logic       rcv_vld, rcv_parity_err, rcv_frame_err, idle;

  wire clk_line  = ~(dut_clk_w | host_clk_w);
  wire data_line = ~(dut_data_w | host_data_w);

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int n_ack = 0, n_done = 0, n_abort = 0, n_vld = 0, n_ferr = 0;
  int n_overlap = 0, n_long = 0;
  int last_ack_cyc = 0, last_vld_cyc = 0;
  logic [7:0] vld_data = 8'd0;
  logic       vld_perr = 1'b0;
  logic [4:0] prev_p = 5'd0;
  bit         fall_q[$];

  wire [4:0] cur_p = {send_ack, send_done, send_abort, rcv_vld, rcv_frame_err};

  ps2_device_core #(.CLK(CLK_MHZ), .HALF_US(HALF), .IDLE_US(IDLE_T)) dut (
    .clk(clk), .rst(rst),
    .ps2_clk_i(clk_line), .ps2_clk_w(dut_clk_w), .ps2_clk_o(dut_clk_o),
    .ps2_data_i(data_line), .ps2_data_w(dut_data_w), .ps2_data_o(dut_data_o),
    .send_req(send_req), .send_data(send_data),
    .send_ack(send_ack), .send_done(send_done), .send_abort(send_abort),
    .rcv_data(rcv_data), .rcv_vld(rcv_vld), .rcv_parity_err(rcv_parity_err),
    .rcv_frame_err(rcv_frame_err), .idle(idle)
  );

  always #5 clk = ~clk;

  // Record the data line shortly after every PS2 clock fall.
  always @(negedge clk_line) begin
    #1;
    fall_q.push_back(data_line);
  end

  // Pulse bookkeeping, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (send_ack) begin
      n_ack <= n_ack + 1;
      last_ack_cyc <= cyc;
    end
    if (send_done)  n_done  <= n_done + 1;
    if (send_abort) n_abort <= n_abort + 1;
    if (rcv_vld) begin
      n_vld <= n_vld + 1;
      last_vld_cyc <= cyc;
      vld_data <= rcv_data;
      vld_perr <= rcv_parity_err;
    end
    if (rcv_frame_err) n_ferr <= n_ferr + 1;
    if ((send_ack | send_done | send_abort) && (rcv_vld | rcv_frame_err)) n_overlap <= n_overlap + 1;
    if (|(cur_p & prev_p)) n_long <= n_long + 1;
    prev_p <= cur_p;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame bit k of a device-to-host byte.
  function automatic bit exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9) return ($countones(d) % 2 == 0);
    return 1'b1;
  endfunction

  function automatic int pulse_cnt(input int sel);
    case (sel)
      0: return n_ack;
      1: return n_done;
      2: return n_abort;
      3: return n_vld;
      4: return n_ferr;
      5: return fall_q.size();
      default: return 0;
    endcase
  endfunction

  task automatic wait_cnt(input string tag, input int sel, input int target, input int budget);
    int k = 0;
    while (pulse_cnt(sel) < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_reached"}, 32'(pulse_cnt(sel) >= target), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] d);
    check_eq({tag, "_nfall"}, fall_q.size(), 32'd11);
    for (int k = 0; k < 11 && k < fall_q.size(); k++)
      check_eq({tag, "_bit"}, 32'(fall_q[k]), 32'(exp_bit(d, k)));
  endtask

  task automatic do_tx(input string tag, input logic [7:0] d);
    int a0 = n_ack;
    int d0 = n_done;
    fall_q.delete();
    send_data = d;
    send_req  = 1'b1;
    wait_cnt({tag, "_ack"}, 0, a0 + 1, 200);
    send_req = 1'b0;
    wait_cnt({tag, "_done"}, 1, d0 + 1, 30 * T);
    repeat (4) @(negedge clk);
    check_frame(tag, d);
    check_eq({tag, "_idle"}, {idle, dut_clk_w, dut_data_w}, 3'b100);
  endtask

  task automatic do_rx(input string tag, input logic [7:0] d, input bit par,
                       input bit stop, input bit with_req);
    int v0 = n_vld;
    int f0 = n_ferr;
    host_clk_w = 1'b1;
    repeat (6) @(negedge clk);
    host_data_w = 1'b1;
    repeat (2) @(negedge clk);
    fall_q.delete();
    host_clk_w = 1'b0;
    if (with_req) send_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      wait_cnt({tag, "_fall"}, 5, i, 4 * T + 20);
      if (i <= 8)      host_data_w = ~d[i-1];
      else if (i == 9) host_data_w = ~par;
      else             host_data_w = ~stop;
    end
    if (stop) begin
      wait_cnt({tag, "_vld"}, 3, v0 + 1, 4 * T + 20);
      repeat (2) @(negedge clk);
      check_eq({tag, "_nfall"}, fall_q.size(), 32'd11);
      if (fall_q.size() >= 11) check_eq({tag, "_ackdata"}, 32'(fall_q[10]), 32'd0);
      check_eq({tag, "_data"}, vld_data, d);
      check_eq({tag, "_perr"}, vld_perr, 32'(($countones(d) + par) % 2 == 0));
    end else begin
      repeat (6) @(negedge clk);
      host_data_w = 1'b0;
      wait_cnt({tag, "_ferr"}, 4, f0 + 1, 4 * T + 20);
      repeat (2) @(negedge clk);
      check_eq({tag, "_novld"}, n_vld, v0);
      check_eq({tag, "_nfall"}, fall_q.size(), 32'd10);
    end
  endtask

  initial begin
    logic [7:0] rd;
    int a0, ab0, dn0, k;
    bit early_bits[4];

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("reset_outs", {dut_clk_w, dut_data_w, dut_clk_o, dut_data_o, send_ack, send_done,
                            send_abort, rcv_vld, rcv_parity_err, rcv_frame_err}, 32'd0);
    check_eq("reset_rcv_data", rcv_data, 32'd0);
    check_eq("reset_idle", idle, 32'd1);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 1: send 0xA5, then random bytes
    do_tx("t1_a5", 8'hA5);
    for (int n = 0; n < 3; n++) begin
      rd = 8'($urandom_range(0, 255));
      do_tx("tx_rand", rd);
    end

    // 2, 3: host sends 0xF4 with good and bad parity, then random frames
    do_rx("t2_f4", 8'hF4, 1'b0, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    do_rx("t3_f4", 8'hF4, 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) begin
      repeat (10) @(negedge clk);
      rd = 8'($urandom_range(0, 255));
      do_rx("rx_rand", rd, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
    repeat (10) @(negedge clk);
    do_rx("rx_ferr", 8'h3C, 1'b1, 1'b0, 1'b0);

    // 4: host inhibits during the HIGH phase of bit 4
    repeat (10) @(negedge clk);
    ab0 = n_abort;
    dn0 = n_done;
    a0  = n_ack;
    fall_q.delete();
    send_data = 8'h5A;
    send_req  = 1'b1;
    wait_cnt("t4_ack", 0, a0 + 1, 200);
    send_req = 1'b0;
    wait_cnt("t4_fall4", 5, 4, 20 * T);
    for (int j = 0; j < 4; j++) early_bits[j] = (j < fall_q.size()) ? fall_q[j] : 1'b1;
    k = 0;
    while (!clk_line && k < 3 * T) begin
      @(negedge clk);
      k++;
    end
    check_eq("t4_high_seen", clk_line, 32'd1);
    host_clk_w = 1'b1;
    wait_cnt("t4_abort", 2, ab0 + 1, 4 * T);
    repeat (2) @(negedge clk);
    for (int j = 0; j < 4; j++) check_eq("t4_bit", 32'(early_bits[j]), 32'(exp_bit(8'h5A, j)));
    check_eq("t4_released", {dut_clk_w, dut_data_w, idle}, 3'b001);
    repeat (10) @(negedge clk);
    host_clk_w = 1'b0;
    repeat (30 * T) @(negedge clk);
    check_eq("t4_no_done", n_done, dn0);
    check_eq("t4_one_abort", n_abort, ab0 + 1);

    // 5: send_req together with host RTS
    a0 = n_ack;
    rd = 8'($urandom_range(0, 255));
    send_data = 8'h96;
    do_rx("t5_rx", rd, 1'b1, 1'b1, 1'b1);
    check_eq("t5_rx_first", n_ack, a0);
    fall_q.delete();
    dn0 = n_done;
    wait_cnt("t5_ack", 0, a0 + 1, 100);
    send_req = 1'b0;
    check_eq("t5_gap_gt_I", 32'((last_ack_cyc - last_vld_cyc) > I), 32'd1);
    wait_cnt("t5_done", 1, dn0 + 1, 30 * T);
    repeat (4) @(negedge clk);
    check_frame("t5_tx", 8'h96);

    // 6: reset during the LOW phase of bit 6
    repeat (10) @(negedge clk);
    a0 = n_ack;
    fall_q.delete();
    send_data = 8'h0F;
    send_req  = 1'b1;
    wait_cnt("t6_ack", 0, a0 + 1, 200);
    send_req = 1'b0;
    wait_cnt("t6_fall7", 5, 7, 20 * T);
    check_eq("t6_pre_drive", {dut_clk_w, dut_data_w}, 2'b11);
    dn0 = n_done;
    ab0 = n_abort;
    rst = 1'b0;
    #1;
    check_eq("t6_released", {dut_clk_w, dut_data_w}, 2'b00);
    check_eq("t6_pulses", {send_ack, send_done, send_abort, rcv_vld, rcv_frame_err}, 5'd0);
    check_eq("t6_idle", idle, 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (30 * T) @(negedge clk);
    check_eq("t6_no_done", n_done, dn0);
    check_eq("t6_no_abort", n_abort, ab0);
    check_eq("t6_idle_after", {idle, dut_clk_w, dut_data_w}, 3'b100);

    // Pulse discipline over the whole run
    check_eq("pulse_overlap", n_overlap, 32'd0);
    check_eq("pulse_width", n_long, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
